// File: rtl/mem_xfer_ctrl.sv
// Memory transfer sequencer: steps MAR/MDR loads and memory strobes for one
// read or write request, with a wait-state handshake and a watchdog abort.
module mem_xfer_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             write,
  input  logic             mem_ready,
  output logic             busy,
  output logic             MARin,
  output logic             MDRin,
  output logic             Read,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_MAR, S_LD_MDR, S_RD_WAIT, S_RD_CAPT, S_WR_WAIT, S_DONE, S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic             dir;
  logic [CNT_W-1:0] cnt_nxt;
  logic             in_wait;
  logic             timed_out;

  assign in_wait   = (state == S_RD_WAIT) || (state == S_WR_WAIT);
  // mem_ready on the final wait cycle takes priority over the abort
  assign timed_out = in_wait && !mem_ready && (wait_cnt == CNT_LAST);
  assign cnt_nxt   = (in_wait && !mem_ready && !timed_out) ? wait_cnt + 1'b1 : '0;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state    <= S_IDLE;
      dir      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      if (state == S_IDLE && start)
        dir <= write;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_LD_MAR;
      S_LD_MAR:  state_nxt = dir ? S_LD_MDR : S_RD_WAIT;
      S_LD_MDR:  state_nxt = S_WR_WAIT;
      S_RD_WAIT: begin
        if (mem_ready)      state_nxt = S_RD_CAPT;
        else if (timed_out) state_nxt = S_ERR;
      end
      S_RD_CAPT: state_nxt = S_DONE;
      S_WR_WAIT: begin
        if (mem_ready)      state_nxt = S_DONE;
        else if (timed_out) state_nxt = S_ERR;
      end
      S_DONE:    state_nxt = S_IDLE;
      S_ERR:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != S_IDLE);
    MARin       = 1'b0;
    MDRin       = 1'b0;
    Read        = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    done        = 1'b0;
    timeout_err = 1'b0;
    case (state)
      S_LD_MAR:  MARin = 1'b1;
      S_LD_MDR:  MDRin = 1'b1;
      S_RD_WAIT: mem_rd = 1'b1;
      S_RD_CAPT: begin
        mem_rd = 1'b1;
        MDRin  = 1'b1;
        Read   = 1'b1;
      end
      S_WR_WAIT: mem_wr = 1'b1;
      S_DONE:    done = 1'b1;
      S_ERR:     timeout_err = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Randomized bench for mem_xfer_ctrl: each transfer's expected per-cycle
// output trace is built from the state/timing table and compared cycle by cycle.
module tb_mem_xfer_ctrl;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  logic             clock = 1'b0;
  logic             clear_n, start, write, mem_ready;
  logic             busy, MARin, MDRin, Read, mem_rd, mem_wr, done, timeout_err;
  logic [CNT_W-1:0] wait_cnt;

  int checks = 0;
  int errors = 0;

  mem_xfer_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .write(write),
    .mem_ready(mem_ready), .busy(busy), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .mem_rd(mem_rd), .mem_wr(mem_wr), .done(done),
    .timeout_err(timeout_err), .wait_cnt(wait_cnt)
  );

  always #5 clock = ~clock;

  // {busy, MARin, MDRin, Read, mem_rd, mem_wr, done, timeout_err}
  logic [7:0] outv;
  assign outv = {busy, MARin, MDRin, Read, mem_rd, mem_wr, done, timeout_err};

  localparam logic [7:0] O_LD_MAR  = 8'b1100_0000;
  localparam logic [7:0] O_LD_MDR  = 8'b1010_0000;
  localparam logic [7:0] O_RD_WAIT = 8'b1000_1000;
  localparam logic [7:0] O_WR_WAIT = 8'b1000_0100;
  localparam logic [7:0] O_RD_CAPT = 8'b1011_1000;
  localparam logic [7:0] O_DONE    = 8'b1000_0010;
  localparam logic [7:0] O_ERR     = 8'b1000_0001;

  // Bench-side MAR/MDR registers driven by the sequencer's enables
  logic [31:0] bus, mdatain, mar, mdr;
  always @(posedge clock) begin
    if (MARin) mar <= bus;
    if (MDRin) mdr <= Read ? mdatain : bus;
  end

  typedef struct {
    logic [7:0] outs;
    int         cnt;
    bit         is_wait;
    bit         rdy;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t mk(logic [7:0] o, int c, bit w, bit r);
    exp_t e;
    e.outs = o; e.cnt = c; e.is_wait = w; e.rdy = r;
    return e;
  endfunction

  // k = number of mem_ready-low wait cycles before acknowledge; k >= TIMEOUT means none
  task automatic build(input bit dir, input int k);
    int nw;
    exp_q.delete();
    exp_q.push_back(mk(O_LD_MAR, 0, 0, 0));
    if (dir) exp_q.push_back(mk(O_LD_MDR, 0, 0, 0));
    nw = (k < TIMEOUT) ? k + 1 : TIMEOUT;
    for (int j = 0; j < nw; j++)
      exp_q.push_back(mk(dir ? O_WR_WAIT : O_RD_WAIT, j, 1, j == k));
    if (k >= TIMEOUT) begin
      exp_q.push_back(mk(O_ERR, 0, 0, 0));
    end else begin
      if (!dir) exp_q.push_back(mk(O_RD_CAPT, 0, 0, 0));
      exp_q.push_back(mk(O_DONE, 0, 0, 0));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("idle_out", {24'd0, outv}, 32'd0);
      chk("idle_cnt", {28'd0, wait_cnt}, 32'd0);
      start     = 1'b0;
      write     = 1'($urandom % 2);
      mem_ready = 1'($urandom % 2);
    end
  endtask

  task automatic run_xfer(input bit dir, input int k);
    logic [31:0] addr, wdata, rdata, other;
    exp_t e;
    addr = $urandom; wdata = $urandom; rdata = $urandom; other = ~rdata ^ wdata;
    build(dir, k);
    @(negedge clock);
    chk("pre_idle", {24'd0, outv}, 32'd0);
    start     = 1'b1;
    write     = dir;
    bus       = addr;
    mdatain   = dir ? other : rdata;
    mem_ready = 1'($urandom % 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      e = exp_q[i];
      chk($sformatf("out[%0d] dir%0d k%0d", i, dir, k), {24'd0, outv}, {24'd0, e.outs});
      chk($sformatf("cnt[%0d] dir%0d k%0d", i, dir, k), {28'd0, wait_cnt}, e.cnt);
      start = 1'($urandom % 4 == 0);
      write = 1'($urandom % 2);
      if (i == 1) bus = dir ? wdata : other;
      mem_ready = e.is_wait ? e.rdy : 1'($urandom % 2);
    end
    chk("mar", mar, addr);
    if (k < TIMEOUT) chk(dir ? "mdr_wr" : "mdr_rd", mdr, dir ? wdata : rdata);
  endtask

  task automatic reset_mid();
    @(negedge clock);
    chk("rst_pre_idle", {24'd0, outv}, 32'd0);
    start = 1'b1; write = 1'($urandom % 2); mem_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat ($urandom_range(0, 8)) @(negedge clock);
    #2 clear_n = 1'b0;
    #1;
    chk("rst_async_out", {24'd0, outv}, 32'd0);
    chk("rst_async_cnt", {28'd0, wait_cnt}, 32'd0);
    @(negedge clock);
    chk("rst_hold_out", {24'd0, outv}, 32'd0);
    clear_n = 1'b1;
    idle(3);
  endtask

  initial begin
    clear_n = 1'b0; start = 1'b0; write = 1'b0; mem_ready = 1'b0;
    bus = '0; mdatain = '0;
    repeat (2) @(negedge clock);
    chk("reset_out", {24'd0, outv}, 32'd0);
    chk("reset_cnt", {28'd0, wait_cnt}, 32'd0);
    clear_n = 1'b1;
    idle(2);

    run_xfer(1'b0, 0);
    run_xfer(1'b1, 3);
    run_xfer(1'b0, TIMEOUT);
    run_xfer(1'b0, TIMEOUT - 1);
    run_xfer(1'b1, TIMEOUT);
    run_xfer(1'b1, TIMEOUT - 1);
    idle(4);
    repeat (3) reset_mid();

    for (int n = 0; n < 40; n++) begin
      run_xfer(1'($urandom % 2), ($urandom % 8 == 0) ? TIMEOUT : int'($urandom_range(0, 6)));
      if ($urandom % 2 == 1) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
